// File: rtl/minute_second_pkg.sv
// Shared constants and step helpers for the seconds/minutes timebase.
package minute_second_pkg;

    localparam logic [5:0] SEC_MAX          = 6'd59;
    localparam logic [5:0] MIN_MAX          = 6'd59;
    localparam int         TICK_DIV_DEFAULT = 50_000_000;

    // Anything at or above the limit wraps to 0, so out-of-range values self-heal.
    function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] step_down(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/led7_decoder.sv
// BCD to 7-segment decoder, segments {g,f,e,d,c,b,a} active-high; blank when disabled.
module led7_decoder (
    input  logic       en,
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (en) begin
            case (digit)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = 7'h00;
            endcase
        end
    end

endmodule

// File: rtl/minute_second_tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, held at 0 while hold is high.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk50,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == LAST) && !hold;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (hold || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/separate.sv
// Splits a 0..59 binary value into decimal tens and units digits.
module separate (
    input  logic [5:0] value,
    output logic [3:0] tens,
    output logic [3:0] units
);

    assign tens  = 4'(value / 6'd10);
    assign units = 4'(value % 6'd10);

endmodule

// File: rtl/minute_second.sv
// Seconds/minutes counter with hour carry, manual minute adjust and 4-digit display.
module minute_second
    import minute_second_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       adj_en,
    input  logic       control0,
    input  logic       control1,
    output logic       equal60,
    output logic       disable_hour,
    output logic [6:0] led_m2,
    output logic [6:0] led_m1,
    output logic [6:0] led_s2,
    output logic [6:0] led_s1
);

    logic       tick;
    logic       press;
    logic [5:0] sec_reg;
    logic [5:0] min_reg;
    logic       lock_reg;
    logic       equal60_reg;
    logic       disable_reg;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk50 (clk50),
        .reset (reset),
        .hold  (adj_en),
        .tick  (tick)
    );

    // A press is only the first sampled low of the button; lock masks the hold.
    assign press = !control1 && !lock_reg;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            sec_reg     <= 6'd0;
            min_reg     <= 6'd0;
            lock_reg    <= 1'b0;
            equal60_reg <= 1'b0;
            disable_reg <= 1'b0;
        end else begin
            disable_reg <= adj_en;

            if (press) begin
                lock_reg <= 1'b1;
            end else if (control1 && lock_reg) begin
                lock_reg <= 1'b0;
            end

            if (adj_en) begin
                sec_reg     <= 6'd0;
                equal60_reg <= 1'b0;
                if (press) begin
                    min_reg <= control0 ? step_up(min_reg, MIN_MAX)
                                        : step_down(min_reg, MIN_MAX);
                end
            end else if (tick) begin
                sec_reg     <= step_up(sec_reg, SEC_MAX);
                equal60_reg <= 1'b0;
                if (sec_reg >= SEC_MAX) begin
                    min_reg <= step_up(min_reg, MIN_MAX);
                    if (min_reg >= MIN_MAX) begin
                        equal60_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign equal60      = equal60_reg;
    assign disable_hour = disable_reg;

    // Digit order: 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens.
    logic [1:0][5:0] value;
    logic [3:0][3:0] digit;
    logic [3:0][6:0] seg;

    assign value[0] = sec_reg;
    assign value[1] = min_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sep
            separate u_sep (
                .value (value[gi]),
                .tens  (digit[2*gi+1]),
                .units (digit[2*gi])
            );
        end
        for (gi = 0; gi < 4; gi++) begin : g_dec
            led7_decoder u_dec (
                .en    (1'b1),
                .digit (digit[gi]),
                .seg   (seg[gi])
            );
        end
    endgenerate

    assign led_s1 = seg[0];
    assign led_s2 = seg[1];
    assign led_m1 = seg[2];
    assign led_m2 = seg[3];

endmodule

// File: doc/minute_second.md
# minute_second

Seconds/minutes timebase of the digital clock. Divides `clk50` down to a 1 Hz tick, counts seconds 0–59 and minutes 0–59, and drives four 7-segment digits. It is the producing end of the hour carry interface: it generates `equal60` and `disable_hour` exactly as the hour counter consumes them. It also supports manual minute adjustment with the same push-button convention as the hour block.

## Interface
- `TICK_DIV`, default 50_000_000: `clk50` cycles per seconds tick. The bench uses small values.
- `clk50` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `adj_en` input 1: 1 = minute-adjust mode.
- `control0` input 1: step direction in adjust mode; 1 = up, 0 = down.
- `control1` input 1: step button, active-low (0 = pressed).
- `equal60` output 1: hour carry, a registered level.
- `disable_hour` output 1: registered copy of `adj_en`; tells the hour block to ignore the carry.
- `led_m2`, `led_m1` output 7 each: minutes tens and units segments.
- `led_s2`, `led_s1` output 7 each: seconds tens and units segments.

## Operation
- Reset values:
  - prescaler 0, `sec` 0, `min` 0, `lock` 0.
  - `equal60` 0, `disable_hour` 0.
  - Displays therefore show 00:00.
- Prescaler counts from 0 to `TICK_DIV`-1. `tick` is high for the single cycle in which prescaler == `TICK_DIV`-1; prescaler wraps to 0 on that cycle.
- Run mode (`adj_en`=0), on `tick`:
  - `sec` < 59: `sec` + 1.
  - `sec` == 59: `sec` ← 0 and `min` steps.
  - `min` < 59: `min` + 1.
  - `min` == 59: `min` ← 0 and `equal60` ← 1.
- `equal60` clears on the next `tick`, or immediately when `adj_en` = 1. It is never set by a manual adjustment.
- Adjust mode (`adj_en`=1):
  - Prescaler is held at 0 and `sec` is forced to 0.
  - `equal60` is forced to 0; `disable_hour` is 1 from the following edge.
- Step button, using lock-flag edge detection:
  - `control1`=0 and `lock`=0: set `lock` ← 1. If `adj_en`=1, step `min`.
  - `control1`=1 and `lock`=1: set `lock` ← 0.
  - `lock` tracks the button in both modes. Only adjust mode changes `min`.
- Step arithmetic:
  - Up: 59 → 0, otherwise +1.
  - Down: 0 → 59, otherwise −1.
- Counters are 6-bit unsigned. Values above 59 are unreachable; if seen, the next up-step or tick loads 0.
- Display: each counter is split into tens and units, and each digit drives an always-enabled 7-segment decoder.

## Timing
- All state updates on `posedge clk50`. `reset` low clears everything immediately, independent of the clock.
- Seconds advance exactly every `TICK_DIV` cycles in run mode.
- Carry timing:
  - `equal60` rises on the same edge that `min` and `sec` both become 0 by counting.
  - It stays high for exactly `TICK_DIV` cycles, one full second.
  - The hour block increments once per high level.
- Button latency: one edge from press (`control1` falling, sampled) to the `min` update. Further steps require release, then a new press. A held button gives one step.
- Simultaneous events:
  - `adj_en`=1 with `tick`: the tick is discarded.
  - Press with `tick` in run mode: the tick proceeds and the press only sets `lock`.
- Leaving adjust mode: the prescaler restarts from 0, so the first tick comes `TICK_DIV` cycles later. `disable_hour` drops one edge after `adj_en`.
- Segment outputs are combinational from the counters.

## Structure
- Constants `SEC_MAX`=59, `MIN_MAX`=59 and the default `TICK_DIV` go in the shared clock package.
- Reuse the existing `separate` block (binary to tens/units) twice and `led7_decoder` four times, all with enable tied to 1.
- One natural new sub-module: `tick_gen`, the prescaler producing `tick`, with a `hold` input driven from `adj_en`.

## Test plan
All scenarios use `TICK_DIV`=4.
1. **Reset:** release `reset` → `min`=0, `sec`=0, `equal60`=0, `led_s1` shows "0". First `tick` at cycle 4 after release, then `sec`=1.
2. **Carry:** preload 59:58 via adjust mode plus run → after two ticks, time reads 00:00 and `equal60`=1 for exactly 4 cycles, then 0; `sec`=1.
3. **Adjust wrap:** `adj_en`=1, `control0`=1, `min`=59, one press → `min`=0, `equal60` stays 0 and `disable_hour`=1. With `control0`=0 and one press → `min`=59.
4. **Held button:** `control1` held low for 20 cycles in adjust mode → exactly one step. Release then press → a second step.
5. **Adjust during carry:** assert `adj_en` while `equal60`=1 → `equal60`=0 on the next edge, `sec`=0, and the prescaler is held (no `sec` change for 10 cycles).
6. **Reset mid-operation:** time 12:34, pulse `reset` low between edges → all outputs return to reset values immediately.
